// File: rtl/llc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : llc_bus_ctrl
// Purpose  : Round-robin sequencer for LLC-initiated snoop-bus transactions;
//            issues one bus message, merges peer snoop results, waits for a
//            HITM flush when needed and returns the result to the requester.
// Revision : 1.0 - initial release
// ============================================================================
module llc_bus_ctrl #(
  parameter int         NUM_REQ       = 2,
  parameter int         NUM_SNOOP     = 3,
  parameter logic [3:0] CACHE_ID      = 4'h0,
  parameter int         SNOOP_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [1:0]             resp_snoop,
  output logic                   resp_err,
  output logic                   bus_valid,
  output logic [2:0]             bus_op,
  output logic [31:0]            bus_addr,
  output logic [3:0]             bus_cache_id,
  input  logic                   snoop_valid,
  input  logic [2*NUM_SNOOP-1:0] snoop_result,
  input  logic                   wb_done,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(SNOOP_TIMEOUT + 1);

  // bus_operation_e / snoop_result_e encodings; every other opcode is illegal
  localparam logic [2:0] c_op_read  = 3'd1;
  localparam logic [2:0] c_op_write = 3'd2;
  localparam logic [2:0] c_op_inval = 3'd3;
  localparam logic [2:0] c_op_rwim  = 3'd4;
  localparam logic [1:0] c_snp_nohit = 2'd0;
  localparam logic [1:0] c_snp_hit   = 2'd1;
  localparam logic [1:0] c_snp_hitm  = 2'd2;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_issue   = 3'd1;
  localparam logic [2:0] c_st_snoop   = 3'd2;
  localparam logic [2:0] c_st_wb_wait = 3'd3;
  localparam logic [2:0] c_st_done    = 3'd4;

  localparam logic [TMR_W-1:0] c_tmr_max = TMR_W'(SNOOP_TIMEOUT);

  logic [2:0]       r_state, w_next;
  logic [IDX_W-1:0] r_rr, r_idx, w_win;
  logic [2:0]       r_op;
  logic [31:0]      r_addr;
  logic [1:0]       r_snoop, w_comb;
  logic             r_err;
  logic [TMR_W-1:0] r_timer;
  logic             w_found, w_sel_legal, w_any_hit, w_any_hitm, w_tmo, w_needs_wb;
  logic [2:0]       w_op_arr   [NUM_REQ];
  logic [31:0]      w_addr_arr [NUM_REQ];
  logic [1:0]       w_peer     [NUM_SNOOP];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_op_arr[g]   = req_op[3*g +: 3];
    assign w_addr_arr[g] = req_addr[32*g +: 32];
  end

  for (genvar p = 0; p < NUM_SNOOP; p++) begin : g_peer
    assign w_peer[p] = snoop_result[2*p +: 2];
  end

  function automatic logic [IDX_W-1:0] rr_step(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Search starts one past the last winner so the last winner is lowest priority
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[rr_step(r_rr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_step(r_rr, k);
      end
    end
  end

  assign w_sel_legal = (w_op_arr[w_win] == c_op_read)  || (w_op_arr[w_win] == c_op_write) ||
                       (w_op_arr[w_win] == c_op_inval) || (w_op_arr[w_win] == c_op_rwim);

  // Peer code 2'b11 matches neither HIT nor HITM and so folds into NOHIT
  always_comb begin
    w_any_hit  = 1'b0;
    w_any_hitm = 1'b0;
    for (int p = 0; p < NUM_SNOOP; p++) begin
      if (w_peer[p] == c_snp_hitm) w_any_hitm = 1'b1;
      if (w_peer[p] == c_snp_hit)  w_any_hit  = 1'b1;
    end
    w_comb = w_any_hitm ? c_snp_hitm : (w_any_hit ? c_snp_hit : c_snp_nohit);
  end

  assign w_tmo      = (r_timer == c_tmr_max);
  assign w_needs_wb = (r_op == c_op_read) || (r_op == c_op_rwim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:    if (w_found) w_next = w_sel_legal ? c_st_issue : c_st_done;
      c_st_issue:   w_next = c_st_snoop;
      c_st_snoop: begin
        if (snoop_valid)
          w_next = (w_comb == c_snp_hitm && w_needs_wb) ? c_st_wb_wait : c_st_done;
        else if (w_tmo)
          w_next = c_st_done;
      end
      c_st_wb_wait: if (wb_done || w_tmo) w_next = c_st_done;
      c_st_done:    w_next = c_st_idle;
      default:      w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= IDX_W'(NUM_REQ - 1);
      r_idx   <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_snoop <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      if (w_next != r_state) r_timer <= '0;
      else if (!w_tmo)       r_timer <= r_timer + 1'b1;
      if (r_state == c_st_idle && w_found) begin
        r_rr    <= w_win;
        r_idx   <= w_win;
        r_op    <= w_op_arr[w_win];
        r_addr  <= w_addr_arr[w_win];
        r_err   <= !w_sel_legal;
        r_snoop <= c_snp_nohit;
      end
      if (r_state == c_st_snoop && snoop_valid) r_snoop <= w_comb;
    end
  end

  always_comb begin
    req_ready    = '0;
    resp_valid   = '0;
    resp_snoop   = '0;
    resp_err     = 1'b0;
    bus_valid    = 1'b0;
    bus_op       = '0;
    bus_addr     = '0;
    bus_cache_id = '0;
    busy         = (r_state != c_st_idle);
    case (r_state)
      c_st_idle: if (w_found) req_ready = NUM_REQ'(1) << w_win;
      c_st_issue: begin
        bus_valid    = 1'b1;
        bus_op       = r_op;
        bus_addr     = r_addr;
        bus_cache_id = CACHE_ID;
      end
      c_st_done: begin
        resp_valid = NUM_REQ'(1) << r_idx;
        resp_snoop = r_snoop;
        resp_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
